mem_access_stage: RTL and testbench

//  RV32I MEM stage, directly downstream of the EX/MEM pipeline register.

---
 rtl/mem_access_stage_if.sv | 31 +++
 rtl/mem_access_stage.sv | 177 +++++++++++++++++
 tb/tb_mem_access_stage.sv | 313 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_if.sv
// Data-memory req/ack bus between the MEM stage and the data memory.
// The stage is the master; memory answers with rdata and a one-cycle ack.
interface mem_access_stage_if;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [3:0]  dmem_be;
    logic [31:0] dmem_wdata;
    logic [31:0] dmem_rdata;
    logic        dmem_ack;

    modport master (
        output dmem_req,
        output dmem_we,
        output dmem_addr,
        output dmem_be,
        output dmem_wdata,
        input  dmem_rdata,
        input  dmem_ack
    );

    modport slave (
        input  dmem_req,
        input  dmem_we,
        input  dmem_addr,
        input  dmem_be,
        input  dmem_wdata,
        output dmem_rdata,
        output dmem_ack
    );
endinterface

// File: rtl/mem_access_stage.sv
// RV32I MEM stage: turns EX/MEM load/store controls into a req/ack
// memory transaction with lane formatting, misalign check and timeout.
module mem_access_stage #(
    parameter int unsigned TIMEOUT = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic [31:0]         alu_out_in,
    input  logic [31:0]         rs2_in,
    input  logic [4:0]          rd_in,
    input  logic [2:0]          funct3_in,
    input  logic                mem_val_in,
    input  logic                mem_rw_in,
    input  logic                wb_sel_in,
    input  logic                reg_we_in,
    mem_access_stage_if.master  dmem,
    output logic                stall,
    output logic [31:0]         wb_data_out,
    output logic [4:0]          rd_out,
    output logic                reg_we_out,
    output logic                misalign_out,
    output logic                bus_err_out
);

    typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;

    state_t      state_q, state_d;
    logic        req_q, req_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  off_q, off_d;
    logic [3:0]  be_q, be_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] ldata_q, ldata_d;
    logic [31:0] timer_q, timer_d;
    logic        berr_q, berr_d;

    logic [1:0]  a;
    logic [3:0]  fmt_be;
    logic [31:0] fmt_wdata;
    logic [31:0] lane;
    logic [31:0] fmt_ldata;

    assign a = alu_out_in[1:0];

    always_comb begin
        misalign_out = 1'b0;
        if (mem_val_in) begin
            unique case (funct3_in[1:0])
                2'b00:   misalign_out = 1'b0;
                2'b01:   misalign_out = a[0];
                2'b10:   misalign_out = |a;
                default: misalign_out = 1'b1;
            endcase
        end
    end

    always_comb begin
        fmt_be    = 4'b1111;
        fmt_wdata = rs2_in;
        unique case (funct3_in[1:0])
            2'b00: begin
                fmt_be    = 4'b0001 << a;
                fmt_wdata = {4{rs2_in[7:0]}};
            end
            2'b01: begin
                fmt_be    = 4'b0011 << a;
                fmt_wdata = {2{rs2_in[15:0]}};
            end
            default: ;
        endcase
    end

    // Lane select uses the offset latched at issue; addr_q is word aligned.
    assign lane = dmem.dmem_rdata >> {off_q, 3'b000};

    always_comb begin
        fmt_ldata = dmem.dmem_rdata;
        unique case (funct3_in)
            3'b000:  fmt_ldata = {{24{lane[7]}}, lane[7:0]};
            3'b100:  fmt_ldata = {24'b0, lane[7:0]};
            3'b001:  fmt_ldata = {{16{lane[15]}}, lane[15:0]};
            3'b101:  fmt_ldata = {16'b0, lane[15:0]};
            default: fmt_ldata = dmem.dmem_rdata;
        endcase
    end

    always_comb begin
        state_d = state_q;
        req_d   = req_q;
        we_d    = we_q;
        addr_d  = addr_q;
        off_d   = off_q;
        be_d    = be_q;
        wdata_d = wdata_q;
        ldata_d = ldata_q;
        timer_d = timer_q;
        berr_d  = berr_q;
        unique case (state_q)
            IDLE: begin
                if (mem_val_in && !misalign_out) begin
                    req_d   = 1'b1;
                    we_d    = mem_rw_in;
                    addr_d  = {alu_out_in[31:2], 2'b00};
                    off_d   = a;
                    be_d    = fmt_be;
                    wdata_d = fmt_wdata;
                    timer_d = '0;
                    state_d = REQ;
                end
            end
            REQ: begin
                timer_d = timer_q + 32'd1;
                // Ack wins over a simultaneous timer expiry.
                if (dmem.dmem_ack) begin
                    ldata_d = we_q ? 32'b0 : fmt_ldata;
                    req_d   = 1'b0;
                    state_d = DONE;
                end else if (TIMEOUT != 0 &&
                             timer_q == TIMEOUT - 1) begin
                    ldata_d = '0;
                    req_d   = 1'b0;
                    berr_d  = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                berr_d  = 1'b0;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            req_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            off_q   <= '0;
            be_q    <= '0;
            wdata_q <= '0;
            ldata_q <= '0;
            timer_q <= '0;
            berr_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            off_q   <= off_d;
            be_q    <= be_d;
            wdata_q <= wdata_d;
            ldata_q <= ldata_d;
            timer_q <= timer_d;
            berr_q  <= berr_d;
        end
    end

    assign dmem.dmem_req   = req_q;
    assign dmem.dmem_we    = we_q;
    assign dmem.dmem_addr  = addr_q;
    assign dmem.dmem_be    = be_q;
    assign dmem.dmem_wdata = wdata_q;

    assign stall = mem_val_in & ~misalign_out & (state_q != DONE);

    assign wb_data_out =
        (wb_sel_in & mem_val_in & ~mem_rw_in & (state_q == DONE))
        ? ldata_q : alu_out_in;

    assign rd_out      = rd_in;
    assign bus_err_out = berr_q;
    assign reg_we_out  = reg_we_in & ~misalign_out & ~berr_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Directed bench for mem_access_stage: a transaction-level model checked
// every cycle, plus literal expectations for the hand-worked scenarios.
module tb_mem_access_stage;

    localparam int unsigned TO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] alu_out_in = '0;
    logic [31:0] rs2_in = '0;
    logic [4:0]  rd_in = '0;
    logic [2:0]  funct3_in = '0;
    logic        mem_val_in = 1'b0;
    logic        mem_rw_in = 1'b0;
    logic        wb_sel_in = 1'b0;
    logic        reg_we_in = 1'b0;
    logic        stall;
    logic [31:0] wb_data_out;
    logic [4:0]  rd_out;
    logic        reg_we_out;
    logic        misalign_out;
    logic        bus_err_out;

    mem_access_stage_if bus();

    mem_access_stage #(.TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .alu_out_in   (alu_out_in),
        .rs2_in       (rs2_in),
        .rd_in        (rd_in),
        .funct3_in    (funct3_in),
        .mem_val_in   (mem_val_in),
        .mem_rw_in    (mem_rw_in),
        .wb_sel_in    (wb_sel_in),
        .reg_we_in    (reg_we_in),
        .dmem         (bus),
        .stall        (stall),
        .wb_data_out  (wb_data_out),
        .rd_out       (rd_out),
        .reg_we_out   (reg_we_out),
        .misalign_out (misalign_out),
        .bus_err_out  (bus_err_out)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    bit cmp_on = 1'b0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Model rules, written from the access-size arithmetic.
    function automatic bit f_mis(input logic [2:0] f3, input logic [31:0] ad);
        int sz;
        sz = int'(f3[1:0]);
        if (sz == 3) return 1'b1;
        return (int'(ad[1:0]) % (1 << sz)) != 0;
    endfunction

    function automatic logic [3:0] f_be(input logic [2:0] f3, input int lo);
        int n;
        n = 1 << int'(f3[1:0]);
        if (n >= 4) return 4'hF;
        return 4'(((1 << n) - 1) << lo);
    endfunction

    function automatic logic [31:0] f_wd(input logic [2:0] f3,
                                         input logic [31:0] r);
        if (f3[1:0] == 2'd0) return 32'(r[7:0]) * 32'h01010101;
        if (f3[1:0] == 2'd1) return 32'(r[15:0]) * 32'h00010001;
        return r;
    endfunction

    function automatic logic [31:0] f_ld(input logic [2:0] f3, input int lo,
                                         input logic [31:0] rd);
        longint v;
        v = longint'(rd >> (8 * lo));
        case (f3)
            3'b000: begin v = v % 256; if (v >= 128) v = v - 256; end
            3'b100: v = v % 256;
            3'b001: begin v = v % 65536; if (v >= 32768) v = v - 65536; end
            3'b101: v = v % 65536;
            default: v = longint'(rd);
        endcase
        return 32'(v);
    endfunction

    bit          m_busy = 0;
    bit          m_done = 0;
    bit          m_berr = 0;
    bit          m_we = 0;
    int          m_wait = 0;
    int          m_lo = 0;
    logic [31:0] m_addr = '0;
    logic [31:0] m_wd = '0;
    logic [31:0] m_ld = '0;
    logic [3:0]  m_be = '0;

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_busy <= 0; m_done <= 0; m_berr <= 0; m_we <= 0;
            m_wait <= 0; m_lo <= 0;
            m_addr <= '0; m_wd <= '0; m_ld <= '0; m_be <= '0;
        end else if (m_done) begin
            m_done <= 0;
            m_berr <= 0;
        end else if (m_busy) begin
            if (bus.dmem_ack) begin
                m_busy <= 0;
                m_done <= 1;
                m_ld <= m_we ? 32'd0 : f_ld(funct3_in, m_lo, bus.dmem_rdata);
            end else if (TO != 0 && m_wait == int'(TO) - 1) begin
                m_busy <= 0;
                m_done <= 1;
                m_ld <= '0;
                m_berr <= 1;
            end else begin
                m_wait <= m_wait + 1;
            end
        end else if (mem_val_in && !f_mis(funct3_in, alu_out_in)) begin
            m_busy <= 1;
            m_wait <= 0;
            m_addr <= alu_out_in & 32'hFFFF_FFFC;
            m_lo <= int'(alu_out_in[1:0]);
            m_we <= mem_rw_in;
            m_be <= f_be(funct3_in, int'(alu_out_in[1:0]));
            m_wd <= f_wd(funct3_in, rs2_in);
        end
    end

    always @(negedge clk) begin
        if (cmp_on) begin
            logic mis;
            mis = mem_val_in && f_mis(funct3_in, alu_out_in);
            chk("req", bus.dmem_req, m_busy);
            chk("misalign", misalign_out, mis);
            chk("stall", stall, mem_val_in && !mis && !m_done);
            chk("wb_data",
                wb_data_out,
                (wb_sel_in && mem_val_in && !mem_rw_in && m_done)
                    ? m_ld : alu_out_in);
            chk("bus_err", bus_err_out, m_berr);
            chk("reg_we", reg_we_out, reg_we_in && !mis && !m_berr);
            chk("rd_out", rd_out, rd_in);
            if (m_busy) begin
                chk("we", bus.dmem_we, m_we);
                chk("addr", bus.dmem_addr, m_addr);
                chk("be", bus.dmem_be, m_be);
                chk("wdata", bus.dmem_wdata, m_wd);
            end
        end
    end

    // Issue one access; ack arrives in REQ cycle 'delay' when en is set.
    task automatic access(
        input logic [2:0] f3, input logic rw, input logic [31:0] ad,
        input logic [31:0] r2, input logic [31:0] rdat,
        input int delay, input bit en,
        output int st, output int reqc, output logic [31:0] wb,
        output logic berr, output logic rwe,
        output logic we_s, output logic [3:0] be_s, output logic [31:0] wd_s);
        int c;
        bit fin;
        funct3_in = f3; mem_rw_in = rw; alu_out_in = ad; rs2_in = r2;
        rd_in = 5'(ad[6:2] + 5'd1);
        mem_val_in = 1'b1; wb_sel_in = ~rw; reg_we_in = ~rw;
        bus.dmem_rdata = rdat;
        st = 0; reqc = 0; c = 0; fin = 0;
        we_s = 1'b0; be_s = '0; wd_s = '0;
        wb = '0; berr = 1'b0; rwe = 1'b0;
        while (c < 40 && !fin) begin
            @(negedge clk);
            if (bus.dmem_req) reqc++;
            if (c == 1) begin
                we_s = bus.dmem_we; be_s = bus.dmem_be; wd_s = bus.dmem_wdata;
            end
            if (stall) begin
                st++;
                @(posedge clk); #1;
                bus.dmem_ack = en && (c == delay);
                c++;
            end else begin
                wb = wb_data_out; berr = bus_err_out; rwe = reg_we_out;
                fin = 1;
            end
        end
        if (!fin) begin
            total++; bad++;
            $display("FAIL access_bound: stall never dropped, got %0d want <40", c);
        end
        bus.dmem_ack = 1'b0;
        @(posedge clk); #1;
    endtask

    initial begin
        int st, rq;
        logic [31:0] wb, wd;
        logic be_err, rwe, we;
        logic [3:0] be;
        bus.dmem_ack = 1'b0;
        bus.dmem_rdata = '0;
        #3 rst = 1'b0;
        #1;
        chk("rst_req", bus.dmem_req, 0);
        chk("rst_addr", bus.dmem_addr, 0);
        chk("rst_be", bus.dmem_be, 0);
        chk("rst_wdata", bus.dmem_wdata, 0);
        chk("rst_berr", bus_err_out, 0);
        cmp_on = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b1;
        @(posedge clk); #1;

        access(3'b010, 0, 32'h100, 0, 32'hDEADBEEF, 0, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("lw_stall", st, 2);
        chk("lw_wb", wb, 32'hDEADBEEF);
        chk("lw_rwe", rwe, 1);
        chk("lw_be", be, 4'hF);

        access(3'b000, 0, 32'h103, 0, 32'h80FF0000, 0, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("lb_be", be, 4'b1000);
        chk("lb_wb", wb, 32'hFFFFFF80);
        access(3'b100, 0, 32'h103, 0, 32'h80FF0000, 1, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("lbu_wb", wb, 32'h00000080);
        chk("lbu_stall", st, 3);

        access(3'b001, 1, 32'h202, 32'h1234ABCD, 0, 3, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("sh_we", we, 1);
        chk("sh_be", be, 4'b1100);
        chk("sh_wdata", wd, 32'hABCDABCD);
        chk("sh_stall", st, 5);
        chk("sh_wb", wb, 32'h202);

        access(3'b001, 0, 32'h202, 0, 32'h80010000, 0, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("lh_wb", wb, 32'hFFFF8001);
        access(3'b101, 0, 32'h202, 0, 32'h80010000, 0, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("lhu_wb", wb, 32'h00008001);

        access(3'b010, 0, 32'h101, 0, 32'h11111111, 0, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("mis_stall", st, 0);
        chk("mis_req", rq, 0);
        chk("mis_rwe", rwe, 0);
        chk("mis_wb", wb, 32'h101);
        access(3'b011, 0, 32'h100, 0, 0, 0, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("illegal_req", rq, 0);

        access(3'b010, 0, 32'h104, 0, 32'h55AA55AA, int'(TO) - 1, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("late_ack_err", be_err, 0);
        chk("late_ack_wb", wb, 32'h55AA55AA);
        chk("late_ack_stall", st, 17);

        access(3'b010, 0, 32'h108, 0, 32'h12345678, 0, 0,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("to_reqc", rq, 16);
        chk("to_berr", be_err, 1);
        chk("to_rwe", rwe, 0);
        chk("to_wb", wb, 0);

        mem_val_in = 1'b0;
        bus.dmem_ack = 1'b1;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        chk("stray_ack_req", bus.dmem_req, 0);
        @(posedge clk); #1;

        funct3_in = 3'b010; mem_rw_in = 0; alu_out_in = 32'h300;
        mem_val_in = 1'b1; wb_sel_in = 1; reg_we_in = 1;
        @(posedge clk); #1;
        chk("pre_rst_req", bus.dmem_req, 1);
        rst = 1'b0;
        mem_val_in = 1'b0;
        #1 chk("rst_mid_req", bus.dmem_req, 0);
        @(posedge clk); #1;
        bus.dmem_ack = 1'b1; bus.dmem_rdata = 32'hCAFEF00D;
        @(posedge clk); #1;
        bus.dmem_ack = 1'b0;
        rst = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_req", bus.dmem_req, 0);
        chk("post_rst_stall", stall, 0);

        access(3'b000, 1, 32'h001, 32'h000000AB, 0, 0, 1,
               st, rq, wb, be_err, rwe, we, be, wd);
        chk("sb_be", be, 4'b0010);
        chk("sb_wdata", wd, 32'hABABABAB);
        chk("sb_stall", st, 2);

        mem_val_in = 1'b0;
        repeat (2) @(posedge clk);
        #1 cmp_on = 1'b0;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
